// File: rtl/pipe_ctrl_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_chain_pkg
// Description : Shared pipeline control-bundle layout, default side-effect
//               mask and write-back select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_chain_pkg;

    localparam int c_ctrl_w      = 5;

    localparam int c_rf_we       = 0;
    localparam int c_mem_we      = 1;
    localparam int c_mem_re      = 2;
    localparam int c_wb_sel_lsb  = 3;
    localparam int c_wb_sel_msb  = 4;

    // Bits with architectural side effects; these must never leak from a dead stage.
    localparam logic [c_ctrl_w-1:0] c_side_mask_default = 5'b00111;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2,
        WB_SEL_IMM = 2'd3
    } wb_sel_e;

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_chain_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_stage
// Description : One valid+ctrl pipeline register with hold, bubble and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_stage
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int CTRL_W = c_ctrl_w
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_hold,
    input  logic              i_flush,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;

    // Flush only kills the valid bit; the stale ctrl is hidden by output masking.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_valid <= i_valid & ~i_bubble;
            r_ctrl  <= i_bubble ? '0 : i_ctrl;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_chain
// Description : NSTAGE-deep control-bundle pipeline with upstream backpressure,
//               per-stage flush, side-effect masking and a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl_chain
    import pipe_ctrl_chain_pkg::*;
#(
    parameter int                CTRL_W    = c_ctrl_w,
    parameter int                NSTAGE    = 2,
    parameter logic [CTRL_W-1:0] SIDE_MASK = CTRL_W'(c_side_mask_default),
    parameter int                CNT_W     = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [NSTAGE-1:0] stall,
    input  logic [NSTAGE-1:0] flush,
    output logic              in_ready,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [NSTAGE-1:0] w_hold;
    logic [NSTAGE-1:0] w_valid;
    logic [CTRL_W-1:0] w_ctrl [NSTAGE];
    logic              w_last_held;
    logic [CNT_W-1:0]  r_stall_cnt;

    // A stage holds if it or anything downstream of it is stalled.
    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_hold
            assign w_hold[gi] = |stall[NSTAGE-1:gi];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
            logic              w_src_valid;
            logic [CTRL_W-1:0] w_src_ctrl;
            logic              w_src_bubble;

            if (gi == 0) begin : g_head
                assign w_src_valid  = in_valid;
                assign w_src_ctrl   = in_ctrl;
                assign w_src_bubble = 1'b0;
            end else begin : g_body
                assign w_src_valid  = w_valid[gi-1];
                assign w_src_ctrl   = w_ctrl[gi-1];
                assign w_src_bubble = w_hold[gi-1];
            end

            pipe_ctrl_stage #(
                .CTRL_W (CTRL_W)
            ) u_stage (
                .clock    (clock),
                .reset    (reset),
                .i_hold   (w_hold[gi]),
                .i_flush  (flush[gi]),
                .i_bubble (w_src_bubble),
                .i_valid  (w_src_valid),
                .i_ctrl   (w_src_ctrl),
                .o_valid  (w_valid[gi]),
                .o_ctrl   (w_ctrl[gi])
            );
        end
    endgenerate

    assign w_last_held = stall[NSTAGE-1];

    // Counts consecutive held cycles of a live last stage; any release or kill restarts it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (flush[NSTAGE-1] || !w_last_held) begin
            r_stall_cnt <= '0;
        end else if (w_valid[NSTAGE-1] && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready    = ~w_hold[0];
    assign stage_valid = w_valid;
    assign out_valid   = w_valid[NSTAGE-1];
    assign out_ctrl    = w_ctrl[NSTAGE-1] & ~(SIDE_MASK & {CTRL_W{~w_valid[NSTAGE-1]}});
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl_chain
// Description : Self-checking bench for pipe_ctrl_chain (directed + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl_chain;

    localparam int NSTAGE = 2;
    localparam int CTRL_W = 5;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [NSTAGE-1:0] stall = '0;
    logic [NSTAGE-1:0] flush = '0;
    logic              in_ready;
    logic [NSTAGE-1:0] stage_valid;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_valid;
    logic [7:0]        stall_cnt;

    logic              in_ready_s;
    logic [NSTAGE-1:0] stage_valid_s;
    logic [CTRL_W-1:0] out_ctrl_s;
    logic              out_valid_s;
    logic [3:0]        stall_cnt_s;

    typedef struct {
        int                due;
        logic [CTRL_W-1:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic held_edge = 1'b0;

    always #5 clock = ~clock;

    pipe_ctrl_chain dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ctrl     (in_ctrl),
        .stall       (stall),
        .flush       (flush),
        .in_ready    (in_ready),
        .stage_valid (stage_valid),
        .out_ctrl    (out_ctrl),
        .out_valid   (out_valid),
        .stall_cnt   (stall_cnt)
    );

    pipe_ctrl_chain #(.CNT_W(4)) dut_sat (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ctrl     (in_ctrl),
        .stall       (stall),
        .flush       (flush),
        .in_ready    (in_ready_s),
        .stage_valid (stage_valid_s),
        .out_ctrl    (out_ctrl_s),
        .out_valid   (out_valid_s),
        .stall_cnt   (stall_cnt_s)
    );

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                         input logic [NSTAGE-1:0] st, input logic [NSTAGE-1:0] fl);
        in_valid = v;
        in_ctrl  = c;
        stall    = st;
        flush    = fl;
    endtask

    // Advance one clock; any accepted input is queued with its no-stall due cycle.
    task automatic step();
        exp_t e;
        #1;
        if (in_valid && in_ready) begin
            e.due  = cyc + NSTAGE;
            e.ctrl = in_ctrl;
            sb.push_back(e);
        end
        held_edge = stall[NSTAGE-1];
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drain();
        drive(1'b0, '0, '0, '0);
        repeat (NSTAGE + 1) step();
        sb.delete();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_ctrl !== 5'h00) begin errors++; $display("FAIL reset_out_ctrl: got %h want 00", out_ctrl); end
        checks++; if (stage_valid !== 2'b00) begin errors++; $display("FAIL reset_stage_valid: got %b want 00", stage_valid); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_nostall: got %b want 1", in_ready); end
        drive(1'b1, 5'h1F, 2'b10, 2'b00);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_stall: got %b want 0", in_ready); end
        drive(1'b1, 5'h1F, 2'b00, 2'b00);
        step();
        checks++; if (stage_valid !== 2'b00) begin errors++; $display("FAIL reset_clocked_valid: got %b want 00", stage_valid); end
        drive(1'b0, '0, '0, '0);
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic test_flow();
        logic [CTRL_W-1:0] vals [3];
        exp_t e;
        int   popped;
        vals[0] = 5'h01; vals[1] = 5'h06; vals[2] = 5'h19;
        drain();
        popped = 0;
        for (int t = 0; t < 8; t++) begin
            if (t < 3) drive(1'b1, vals[t], '0, '0);
            else       drive(1'b0, '0, '0, '0);
            step();
            if (out_valid && !held_edge) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL flow_unexpected: got ctrl %h want no output", out_ctrl);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    if (out_ctrl !== e.ctrl || cyc != e.due) begin
                        errors++;
                        $display("FAIL flow_out: got %h at cycle %0d want %h at cycle %0d", out_ctrl, cyc, e.ctrl, e.due);
                    end
                end
            end
        end
        checks++; if (popped != 3) begin errors++; $display("FAIL flow_count: got %0d outputs want 3", popped); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   popped;
        int   pushed;
        drain();
        popped = 0;
        pushed = 0;
        for (int t = 0; t < 60; t++) begin
            drive(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                  {($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0)}, '0);
            if (in_valid && in_ready) pushed++;
            step();
            if (out_valid && !held_edge) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got ctrl %h want no output", out_ctrl);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    if (out_ctrl !== e.ctrl) begin
                        errors++; $display("FAIL b2b_out: got %h want %h", out_ctrl, e.ctrl);
                    end
                end
            end
        end
        drive(1'b0, '0, '0, '0);
        for (int t = 0; t < NSTAGE + 2; t++) begin
            step();
            if (out_valid && !held_edge && sb.size() != 0) begin
                e = sb.pop_front();
                popped++;
                checks++;
                if (out_ctrl !== e.ctrl) begin errors++; $display("FAIL b2b_drain: got %h want %h", out_ctrl, e.ctrl); end
            end
        end
        checks++; if (popped != pushed) begin errors++; $display("FAIL b2b_count: got %0d outputs want %0d", popped, pushed); end
    endtask

    task automatic test_stall();
        drain();
        drive(1'b1, 5'h02, '0, '0); step();
        drive(1'b1, 5'h05, '0, '0); step();
        drive(1'b1, 5'h1F, 2'b10, '0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (out_ctrl !== 5'h02 || out_valid !== 1'b1 || stall_cnt !== 8'(k)) begin
                errors++;
                $display("FAIL stall_hold: got ctrl %h valid %b cnt %0d want 02 1 %0d", out_ctrl, out_valid, stall_cnt, k);
            end
        end
        drive(1'b0, '0, '0, '0); step();
        checks++;
        if (stall_cnt !== 8'd0 || out_ctrl !== 5'h05 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got cnt %0d ctrl %h valid %b want 0 05 1", stall_cnt, out_ctrl, out_valid);
        end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_ignored_input: got valid %b ctrl %h want 0", out_valid, out_ctrl); end
    endtask

    task automatic test_bubble();
        drain();
        drive(1'b1, 5'h08, '0, '0); step();
        drive(1'b1, 5'h04, '0, '0); step();
        checks++; if (out_ctrl !== 5'h08 || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_pre: got %h/%b want 08/1", out_ctrl, out_valid); end
        drive(1'b0, '0, 2'b01, '0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_in_ready: got %b want 0", in_ready); end
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'h00 || stage_valid !== 2'b01) begin
            errors++;
            $display("FAIL bubble_insert: got valid %b ctrl %h stages %b want 0 00 01", out_valid, out_ctrl, stage_valid);
        end
        drive(1'b0, '0, '0, '0); step();
        checks++; if (out_ctrl !== 5'h04 || out_valid !== 1'b1) begin errors++; $display("FAIL bubble_follow: got %h/%b want 04/1", out_ctrl, out_valid); end
    endtask

    task automatic test_flush();
        drain();
        drive(1'b1, 5'h03, '0, '0); step();
        drive(1'b1, 5'h10, '0, '0); step();
        drive(1'b1, 5'h1E, 2'b10, '0); step();
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL flush_pre_cnt: got %0d want 1", stall_cnt); end
        drive(1'b1, 5'h1E, 2'b10, 2'b10); step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'h00 || stall_cnt !== 8'd0 || stage_valid !== 2'b01 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_prio: got valid %b ctrl %h cnt %0d stages %b rdy %b want 0 00 0 01 0",
                     out_valid, out_ctrl, stall_cnt, stage_valid, in_ready);
        end
        drive(1'b0, '0, '0, '0); step();
        checks++; if (out_ctrl !== 5'h10 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_upstream_held: got %h/%b want 10/1", out_ctrl, out_valid); end
    endtask

    task automatic test_mask();
        drain();
        drive(1'b1, 5'h1F, '0, '0); step();
        drive(1'b1, 5'h1B, '0, '0); step();
        drive(1'b0, '0, '0, 2'b10); step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'h18) begin
            errors++; $display("FAIL mask_wb_sel: got valid %b ctrl %h want 0 18", out_valid, out_ctrl);
        end
    endtask

    task automatic test_saturation();
        drain();
        drive(1'b1, 5'h07, '0, '0); step();
        drive(1'b0, '0, '0, '0); step();
        drive(1'b0, '0, 2'b10, '0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14 || k == 15 || k == 16 || k == 20) begin
                checks++;
                if (stall_cnt_s !== 4'((k > 15) ? 15 : k)) begin
                    errors++; $display("FAIL sat_cnt4 k=%0d: got %0d want %0d", k, stall_cnt_s, (k > 15) ? 15 : k);
                end
            end
        end
        checks++; if (stall_cnt !== 8'd20) begin errors++; $display("FAIL sat_cnt8: got %0d want 20", stall_cnt); end
        drive(1'b0, '0, '0, '0); step();
        checks++; if (stall_cnt_s !== 4'd0) begin errors++; $display("FAIL sat_clear: got %0d want 0", stall_cnt_s); end
    endtask

    task automatic test_async_reset();
        int  c0;
        logic seen;
        drain();
        drive(1'b1, 5'h0A, '0, '0); step();
        drive(1'b1, 5'h0D, '0, '0); step();
        drive(1'b0, '0, 2'b10, '0); step(); step();
        checks++; if (stage_valid !== 2'b11 || stall_cnt !== 8'd2) begin errors++; $display("FAIL areset_pre: got %b/%0d want 11/2", stage_valid, stall_cnt); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 5'h00 || stage_valid !== 2'b00 || stall_cnt !== 8'd0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got valid %b ctrl %h stages %b cnt %0d rdy %b want 0 00 00 0 0",
                     out_valid, out_ctrl, stage_valid, stall_cnt, in_ready);
        end
        drive(1'b0, '0, '0, '0);
        #1;
        reset = 1'b1;
        step();
        drive(1'b1, 5'h0C, '0, '0);
        c0 = cyc;
        step();
        drive(1'b0, '0, '0, '0);
        seen = out_valid;
        for (int t = 0; t < 10 && !seen; t++) begin
            step();
            seen = out_valid;
        end
        checks++;
        if (!seen || (cyc - c0) != NSTAGE || out_ctrl !== 5'h0C) begin
            errors++;
            $display("FAIL areset_latency: got seen %b after %0d cycles ctrl %h want 1 %0d 0C", seen, cyc - c0, out_ctrl, NSTAGE);
        end
    endtask

    initial begin
        test_reset();
        test_flow();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_flush();
        test_mask();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
